// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU, the sprite-DMA controller and the system bus.
// slave = controller view; master = CPU/bus-side view.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rw;
  logic        cpu_rdy;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
    output bus_addr, bus_data_out, bus_rw, cpu_rdy, dma_active
  );

  modport master (
    output cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
    input  bus_addr, bus_data_out, bus_rw, cpu_rdy, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA arbiter: passes CPU through, and on a write to DMA_REG_ADDR freezes the
// CPU and copies page P to OAM_DATA_ADDR as 256 read/write pairs on get/put parity.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic           clock,
  input  logic           nreset,
  oam_dma_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_get;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_latch;
  logic       w_trigger;

  assign w_trigger = (r_state == S_IDLE) && (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_rw;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_get   <= 1'b1;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_latch <= 8'h00;
    end else begin
      r_state <= w_next_state;
      r_get   <= ~r_get;
      if (w_trigger) begin
        r_page <= bus.cpu_data_out;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ) begin
        r_latch <= bus.bus_data_in;
      end
      // idx parks at FF after the last byte rather than wrapping into a second pass
      if ((r_state == S_WRITE) && (r_idx != 8'hFF)) begin
        r_idx <= r_idx + 8'h01;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    bus.bus_addr     = bus.cpu_addr;
    bus.bus_data_out = bus.cpu_data_out;
    bus.bus_rw       = bus.cpu_rw;
    bus.cpu_rdy      = 1'b1;
    bus.dma_active   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_next_state = S_HALT;
        end
      end
      S_HALT: begin
        bus.bus_rw     = 1'b1;
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        // the next cycle is a get cycle exactly when the current one is not
        w_next_state   = r_get ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        bus.bus_rw     = 1'b1;
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        w_next_state   = S_READ;
      end
      S_READ: begin
        bus.bus_addr   = {r_page, r_idx};
        bus.bus_rw     = 1'b1;
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        w_next_state   = S_WRITE;
      end
      S_WRITE: begin
        bus.bus_addr     = OAM_DATA_ADDR;
        bus.bus_data_out = r_latch;
        bus.bus_rw       = 1'b0;
        bus.cpu_rdy      = 1'b0;
        bus.dma_active   = 1'b1;
        w_next_state     = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule
